// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state encoding,
// parity mode constants and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..CLK_DIV-1 divider, one-clk tick on wrap,
// synchronous clear to re-phase on a start edge.
module uart_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                      cnt <= '0;
    else if (clr || cnt == D_LAST) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == D_LAST) && !clr;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchroniser, 3-sample majority per bit,
// parity/stop checking, valid/ready output with sticky overrun.
module uart_rx_os #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  import uart_pkg::*;

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS);
  localparam logic [BW-1:0] P_LAST = BW'(STOP_BITS - 1);

  uart_state_e          state;
  logic                 rx_m, rx_s;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 s0, s1;
  logic                 perr_int, ferr_int, armed, dlv;
  logic                 tick, start_det, vote_tick, bit_end, vbit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign start_det = (state == ST_IDLE) && !rx_s && armed;
  assign vote_tick = tick && (sample_cnt == S_V2);
  assign bit_end   = tick && (sample_cnt == S_LAST);
  assign vbit      = maj3(s0, s1, rx_s);
  assign busy      = (state != ST_IDLE);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_det),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      perr_int   <= 1'b0;
      ferr_int   <= 1'b0;
      armed      <= 1'b1;
      dlv        <= 1'b0;
    end else begin
      dlv <= 1'b0;
      if (state != ST_IDLE && tick) begin
        sample_cnt <= (sample_cnt == S_LAST) ? '0 : sample_cnt + 1'b1;
        if (sample_cnt == S_V0) s0 <= rx_s;
        if (sample_cnt == S_V1) s1 <= rx_s;
      end
      unique case (state)
        ST_IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (start_det) begin
            state      <= ST_START;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            perr_int   <= 1'b0;
            ferr_int   <= 1'b0;
          end
        end
        ST_START: begin
          if (vote_tick && vbit) state <= ST_IDLE;
          else if (bit_end)      state <= ST_DATA;
        end
        ST_DATA: begin
          if (vote_tick) begin
            shreg   <= {vbit, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (bit_end && bit_cnt == B_LAST) begin
            bit_cnt <= '0;
            state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (vote_tick) perr_int <= (^shreg) ^ vbit ^ (PARITY == PARITY_ODD);
          if (bit_end)   state <= ST_STOP;
        end
        ST_STOP: begin
          // Last stop bit is decided at its vote so the next start edge is never missed.
          if (vote_tick) begin
            ferr_int <= ferr_int | ~vbit;
            if (bit_cnt == P_LAST) begin
              state <= ST_IDLE;
              dlv   <= 1'b1;
              if (ferr_int || !vbit) armed <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (dlv) begin
      if (data_valid && !data_ready) begin
        overrun_err <= 1'b1;
      end else begin
        data_out   <= shreg;
        parity_err <= perr_int;
        frame_err  <= ferr_int;
        data_valid <= 1'b1;
        if (data_valid) overrun_err <= 1'b0;
      end
    end else if (data_valid && data_ready) begin
      data_valid  <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and an 8E1 instance driven with serial frames;
// expected words are queued when a frame is sent and compared when the DUT presents them.
module tb_uart_rx_os;

  localparam int BITCLK = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       ready0 = 1'b0, ready1 = 1'b0;
  logic [7:0] dout0, dout1;
  logic       dv0, dv1, pe0, pe1, fe0, fe1, ov0, ov1, busy0, busy1;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .data_out(dout0), .data_valid(dv0), .data_ready(ready0),
    .parity_err(pe0), .frame_err(fe0), .overrun_err(ov0), .busy(busy0));

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .data_out(dout1), .data_valid(dv1), .data_ready(ready1),
    .parity_err(pe1), .frame_err(fe1), .overrun_err(ov1), .busy(busy1));

  task automatic bit_out(input bit ch, input logic v);
    if (ch) rx1 = v;
    else    rx0 = v;
    repeat (BITCLK) @(negedge clk);
  endtask

  // pbit < 0 means no parity bit; the line is left at the stop level.
  task automatic send_frame(input bit ch, input logic [7:0] d, input int pbit, input logic stop);
    bit_out(ch, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(ch, d[i]);
    if (pbit >= 0) bit_out(ch, pbit[0]);
    bit_out(ch, stop);
  endtask

  task automatic wait_valid(input bit ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (ch ? dv1 : dv0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_valid ch%0d: data_valid never rose within 3000 clk", ch);
    end
  endtask

  task automatic accept(input bit ch);
    if (ch) ready1 = 1'b1; else ready0 = 1'b1;
    @(negedge clk);
    if (ch) ready1 = 1'b0; else ready0 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({dout0, dv0, pe0, fe0, ov0, busy0} !== 13'd0) begin
      fails++; $display("FAIL reset_dut0 got %h want 0", {dout0, dv0, pe0, fe0, ov0, busy0});
    end
    tests++;
    if ({dout1, dv1, pe1, fe1, ov1, busy1} !== 13'd0) begin
      fails++; $display("FAIL reset_dut1 got %h want 0", {dout1, dv1, pe1, fe1, ov1, busy1});
    end
    rst = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    exp_t e;
    bit   ok;
    ready0 = 1'b1;
    sb.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    fork
      send_frame(1'b0, 8'hA5, -1, 1'b1);
      begin
        wait_valid(1'b0, ok);
        if (ok) begin
          e = sb.pop_front();
          tests++;
          if ({dout0, pe0, fe0, ov0} !== {e, 1'b0}) begin
            fails++; $display("FAIL basic_word got %h want %h", {dout0, pe0, fe0, ov0}, {e, 1'b0});
          end
          @(negedge clk);
          tests++;
          if (dv0 !== 1'b0) begin
            fails++; $display("FAIL basic_pulse data_valid got %b want 0", dv0);
          end
        end
      end
    join
    ready0 = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_parity;
    exp_t e;
    bit   ok;
    logic [7:0] d = 8'h03;
    for (int p = 1; p >= 0; p--) begin
      sb.push_back('{d: d, pe: (^d) ^ p[0], fe: 1'b0});
      send_frame(1'b1, d, p, 1'b1);
      wait_valid(1'b1, ok);
      if (ok) begin
        e = sb.pop_front();
        tests++;
        if ({dout1, pe1, fe1} !== e) begin
          fails++; $display("FAIL parity_p%0d got %h want %h", p, {dout1, pe1, fe1}, e);
        end
        accept(1'b1);
      end
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_false_start;
    bit saw_busy = 1'b0, saw_valid = 1'b0;
    rx0 = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_busy |= busy0;
    end
    rx0 = 1'b1;
    repeat (150) begin
      @(negedge clk);
      saw_busy  |= busy0;
      saw_valid |= dv0;
    end
    tests++;
    if (saw_busy !== 1'b1) begin fails++; $display("FAIL false_start_busy got 0 want 1"); end
    tests++;
    if (saw_valid !== 1'b0) begin fails++; $display("FAIL false_start_valid got 1 want 0"); end
    tests++;
    if (busy0 !== 1'b0) begin fails++; $display("FAIL false_start_idle busy got %b want 0", busy0); end
  endtask

  task automatic test_frame_err;
    exp_t e;
    bit   ok;
    bit   restarted = 1'b0;
    sb.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b1});
    send_frame(1'b0, 8'h5A, -1, 1'b0);
    wait_valid(1'b0, ok);
    if (ok) begin
      e = sb.pop_front();
      tests++;
      if ({dout0, pe0, fe0} !== e) begin
        fails++; $display("FAIL frame_err_word got %h want %h", {dout0, pe0, fe0}, e);
      end
      accept(1'b0);
    end
    repeat (300) begin
      @(negedge clk);
      restarted |= busy0;
    end
    tests++;
    if (restarted !== 1'b0) begin fails++; $display("FAIL break_rearm busy got 1 want 0"); end
    rx0 = 1'b1;
    repeat (50) @(negedge clk);
    sb.push_back('{d: 8'h66, pe: 1'b0, fe: 1'b0});
    send_frame(1'b0, 8'h66, -1, 1'b1);
    wait_valid(1'b0, ok);
    if (ok) begin
      e = sb.pop_front();
      tests++;
      if ({dout0, pe0, fe0} !== e) begin
        fails++; $display("FAIL after_break got %h want %h", {dout0, pe0, fe0}, e);
      end
      accept(1'b0);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit   ok;
    sb.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send_frame(1'b0, 8'h11, -1, 1'b1);
    send_frame(1'b0, 8'h22, -1, 1'b1);
    wait_valid(1'b0, ok);
    if (ok) begin
      e = sb.pop_front();
      tests++;
      if ({dout0, pe0, fe0} !== e) begin
        fails++; $display("FAIL overrun_word got %h want %h", {dout0, pe0, fe0}, e);
      end
      tests++;
      if (ov0 !== 1'b1) begin fails++; $display("FAIL overrun_flag got %b want 1", ov0); end
      accept(1'b0);
      tests++;
      if ({dv0, ov0} !== 2'b00) begin
        fails++; $display("FAIL overrun_clear got %b want 00", {dv0, ov0});
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   ok;
    rx0 = 1'b0;
    repeat (BITCLK * 5 + BITCLK / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({dout0, dv0, pe0, fe0, ov0, busy0} !== 13'd0) begin
      fails++; $display("FAIL reset_mid got %h want 0", {dout0, dv0, pe0, fe0, ov0, busy0});
    end
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    rst = 1'b1;
    repeat (50) @(negedge clk);
    sb.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    send_frame(1'b0, 8'h3C, -1, 1'b1);
    wait_valid(1'b0, ok);
    if (ok) begin
      e = sb.pop_front();
      tests++;
      if ({dout0, pe0, fe0, ov0} !== {e, 1'b0}) begin
        fails++; $display("FAIL reset_mid_word got %h want %h", {dout0, pe0, fe0, ov0}, {e, 1'b0});
      end
      accept(1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_parity;
    test_false_start;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
